// File: rtl/fpu_pkg.sv
// Shared FPU constants: default register width, canonical NaNs, NaN-box pattern,
// bypass-source encoding and register-address width derivation.
package fpu_pkg;

   localparam int          FLEN_DEFAULT = 64;
   localparam logic [31:0] CANON_NAN32  = 32'h7FC0_0000;
   localparam logic [63:0] CANON_NAN64  = 64'hFFFF_FFFF_7FC0_0000;
   localparam logic [31:0] NANBOX_UPPER = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      WSRC_NONE = 2'd0,
      WSRC_WA   = 2'd1,
      WSRC_WB   = 2'd2
   } wsrc_e;

   function automatic int addr_width(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/fregs_unbox.sv
// Per-port NaN-box check: a single-precision read of a 64-bit register whose upper
// half is not all ones returns the boxed canonical NaN.
module fregs_unbox
   import fpu_pkg::*;
#(
   parameter int FLEN = FLEN_DEFAULT
)(
   input  logic [FLEN-1:0] data,
   input  logic            single,
   output logic [FLEN-1:0] result
);

   logic boxed_ok_s;

   assign boxed_ok_s = (data[FLEN-1:FLEN-32] == NANBOX_UPPER);

   // substitute the canonical NaN for an improperly boxed single
   always_comb begin
      result = data;
      if ((FLEN == 64) && single && !boxed_ok_s) begin
         result = CANON_NAN64[FLEN-1:0];
      end else begin
         result = data;
      end
   end

endmodule

// File: rtl/fregs_sb.sv
// FP register file with per-register busy scoreboard, a short-pipe write port (wa),
// a handshaked long-latency write port (wb), same-cycle bypass and an FS dirty flag.
module fregs_sb
   import fpu_pkg::*;
#(
   parameter  int FLEN = FLEN_DEFAULT,
   parameter  int NRD  = 3,
   parameter  int NREG = 32,
   localparam int AW   = addr_width(NREG)
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NRD*AW-1:0] rd_addr,
   input  logic [NRD-1:0]    rd_single,
   output logic [NRD*FLEN-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              rsv_valid,
   input  logic [AW-1:0]     rsv_addr,
   output logic              rsv_ready,
   input  logic              wa_en,
   input  logic [AW-1:0]     wa_addr,
   input  logic [FLEN-1:0]   wa_data,
   input  logic              wa_single,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_addr,
   input  logic [FLEN-1:0]   wb_data,
   input  logic              wb_single,
   output logic              wb_ready,
   input  logic              fs_clean,
   output logic              fs_dirty
);

   // upper-half ones; all zero when FLEN is 32 so boxing becomes a no-op
   localparam logic [FLEN-1:0] BOX_MASK = ~FLEN'(32'hFFFF_FFFF);

   function automatic logic [FLEN-1:0] nan_box(input logic [FLEN-1:0] d, input logic single);
      return single ? (d | BOX_MASK) : d;
   endfunction

   logic [FLEN-1:0] regs_r [NREG];
   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] busy_nxt_s;
   logic            fs_dirty_r;
   logic            dirty_nxt_s;
   logic            wb_fire_s;
   logic            rsv_fire_s;
   logic [FLEN-1:0] wa_box_s;
   logic [FLEN-1:0] wb_box_s;

   assign wb_ready   = !(wa_en && (wa_addr == wb_addr));
   assign wb_fire_s  = wb_valid && wb_ready;
   assign rsv_ready  = !busy_r[rsv_addr];
   assign rsv_fire_s = rsv_valid && rsv_ready;
   assign wa_box_s   = nan_box(wa_data, wa_single);
   assign wb_box_s   = nan_box(wb_data, wb_single);
   assign fs_dirty   = fs_dirty_r;

   // scoreboard update: a reservation outranks a clear of the same register
   always_comb begin
      busy_nxt_s = busy_r;
      for (int i = 0; i < NREG; i++) begin
         busy_nxt_s[i] = (rsv_fire_s && (rsv_addr == AW'(i))) ? 1'b1 :
                         ((wa_en && (wa_addr == AW'(i))) ||
                          (wb_fire_s && (wb_addr == AW'(i)))) ? 1'b0 : busy_r[i];
      end
      dirty_nxt_s = (wa_en || wb_fire_s) ? 1'b1 : (fs_clean ? 1'b0 : fs_dirty_r);
   end

   // register storage; wa and wb never target the same register in one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= '0;
         end
      end else begin
         if (wb_fire_s) begin
            regs_r[wb_addr] <= wb_box_s;
         end
         if (wa_en) begin
            regs_r[wa_addr] <= wa_box_s;
         end
      end
   end

   // busy bits and dirty flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r     <= '0;
         fs_dirty_r <= 1'b0;
      end else begin
         busy_r     <= busy_nxt_s;
         fs_dirty_r <= dirty_nxt_s;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr_s;
      logic [FLEN-1:0] raw_s;
      logic [FLEN-1:0] out_s;
      wsrc_e           src_s;

      assign addr_s = rd_addr[k*AW +: AW];

      // bypass selection; nothing is forwarded while reset is held
      always_comb begin
         if (!reset_n) begin
            src_s = WSRC_NONE;
         end else if (wa_en && (wa_addr == addr_s)) begin
            src_s = WSRC_WA;
         end else if (wb_fire_s && (wb_addr == addr_s)) begin
            src_s = WSRC_WB;
         end else begin
            src_s = WSRC_NONE;
         end
      end

      // read mux
      always_comb begin
         case (src_s)
            WSRC_WA: raw_s = wa_box_s;
            WSRC_WB: raw_s = wb_box_s;
            default: raw_s = regs_r[addr_s];
         endcase
      end

      fregs_unbox #(.FLEN(FLEN)) u_unbox (
         .data   (raw_s),
         .single (rd_single[k]),
         .result (out_s)
      );

      assign rd_data[k*FLEN +: FLEN] = out_s;
      assign rd_busy[k]              = busy_r[addr_s];
   end

endmodule

// File: tb/tb_fregs_sb.sv
// Scoreboard bench for fregs_sb (FLEN=64, NRD=3, NREG=32): expectations are queued as
// stimulus is driven and compared against DUT outputs half a cycle later.
module tb_fregs_sb;

   localparam int FLEN = 64;
   localparam int NRD  = 3;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam logic [63:0] NAN64 = 64'hFFFF_FFFF_7FC0_0000;

   localparam int S_RD0 = 0, S_RD1 = 1, S_RD2 = 2, S_BUSY = 3, S_RSVR = 4, S_WBR = 5, S_DIRTY = 6;

   logic clk = 1'b0;
   logic reset_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD-1:0]      rd_single;
   logic [NRD*FLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                rsv_valid;
   logic [AW-1:0]       rsv_addr;
   logic                rsv_ready;
   logic                wa_en;
   logic [AW-1:0]       wa_addr;
   logic [FLEN-1:0]     wa_data;
   logic                wa_single;
   logic                wb_valid;
   logic [AW-1:0]       wb_addr;
   logic [FLEN-1:0]     wb_data;
   logic                wb_single;
   logic                wb_ready;
   logic                fs_clean;
   logic                fs_dirty;

   typedef struct {
      string       tag;
      int          sig;
      logic [63:0] val;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   logic [63:0] mdl [NREG];

   fregs_sb #(.FLEN(FLEN), .NRD(NRD), .NREG(NREG)) dut (
      .clk(clk), .reset_n(reset_n),
      .rd_addr(rd_addr), .rd_single(rd_single), .rd_data(rd_data), .rd_busy(rd_busy),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_single(wa_single),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_single(wb_single),
      .wb_ready(wb_ready), .fs_clean(fs_clean), .fs_dirty(fs_dirty)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int sig);
      case (sig)
         S_RD0, S_RD1, S_RD2: return rd_data[sig*FLEN +: FLEN];
         S_BUSY:  return {61'd0, rd_busy};
         S_RSVR:  return {63'd0, rsv_ready};
         S_WBR:   return {63'd0, wb_ready};
         S_DIRTY: return {63'd0, fs_dirty};
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] box(input logic [63:0] d, input logic s);
      return s ? {32'hFFFF_FFFF, d[31:0]} : d;
   endfunction

   task automatic expect_out(input string tag, input int sig, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check_val(e.tag, observe(e.sig), e.val);
      end
   endtask

   task automatic rd(input int k, input logic [4:0] a, input logic s);
      rd_addr[k*AW +: AW] = a;
      rd_single[k]        = s;
   endtask

   task automatic idle();
      rd_addr = '0; rd_single = '0;
      rsv_valid = 1'b0; rsv_addr = '0;
      wa_en = 1'b0; wa_addr = '0; wa_data = '0; wa_single = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_single = 1'b0;
      fs_clean = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic sample();
      @(negedge clk);
      drain();
   endtask

   initial begin
      logic [63:0] a_v, b_v, c_v, d_v, g_v;
      for (int i = 0; i < NREG; i++) mdl[i] = 64'd0;
      reset_n = 1'b0;
      idle();

      // values while reset is held
      next_cycle();
      rd(0, 5'd5, 1'b0); rd(1, 5'd5, 1'b1); rsv_addr = 5'd5;
      expect_out("rst_rd", S_RD0, 64'd0);
      expect_out("rst_rd_nan", S_RD1, NAN64);
      expect_out("rst_rsv_ready", S_RSVR, 64'd1);
      sample();
      @(posedge clk); #1; reset_n = 1'b1;

      // every register reads zero and idle after reset
      for (int a = 0; a < NREG; a++) begin
         next_cycle();
         rd(0, 5'(a), 1'b0); rd(1, 5'((a + 1) % NREG), 1'b0); rd(2, 5'((a + 2) % NREG), 1'b0);
         rsv_addr = 5'(a);
         expect_out("init_rd0", S_RD0, 64'd0);
         expect_out("init_rd1", S_RD1, 64'd0);
         expect_out("init_busy", S_BUSY, 64'd0);
         expect_out("init_rsv_ready", S_RSVR, 64'd1);
         expect_out("init_dirty", S_DIRTY, 64'd0);
         sample();
      end

      // NaN boxing on write and unboxing check on read
      next_cycle();
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'h1234_5678_3F80_0000; wa_single = 1'b1;
      mdl[5] = box(wa_data, 1'b1);
      rd(0, 5'd5, 1'b1);
      expect_out("box_bypass", S_RD0, 64'hFFFF_FFFF_3F80_0000);
      expect_out("dirty_pre", S_DIRTY, 64'd0);
      sample();
      next_cycle();
      wa_en = 1'b1; wa_addr = 5'd6; wa_data = 64'h0000_0000_3F80_0000; wa_single = 1'b0;
      mdl[6] = box(wa_data, 1'b0);
      rd(0, 5'd5, 1'b0); rd(1, 5'd6, 1'b1); rd(2, 5'd6, 1'b0);
      expect_out("box_stored", S_RD0, mdl[5]);
      expect_out("unbox_nan_byp", S_RD1, NAN64);
      expect_out("raw_bypass", S_RD2, 64'h0000_0000_3F80_0000);
      expect_out("dirty_set", S_DIRTY, 64'd1);
      sample();
      next_cycle();
      rd(0, 5'd6, 1'b1); rd(1, 5'd6, 1'b0); rd(2, 5'd5, 1'b1);
      expect_out("unbox_nan_reg", S_RD0, NAN64);
      expect_out("raw_stored", S_RD1, mdl[6]);
      expect_out("box_ok_reg", S_RD2, 64'hFFFF_FFFF_3F80_0000);
      expect_out("busy_nonres", S_BUSY, 64'd0);
      sample();

      // reservation, clear by wb, re-reservation racing a write
      next_cycle();
      rsv_valid = 1'b1; rsv_addr = 5'd7; rd(0, 5'd7, 1'b0);
      expect_out("rsv_ready_free", S_RSVR, 64'd1);
      expect_out("busy_same_cycle", S_BUSY, 64'd0);
      sample();
      next_cycle();
      rsv_valid = 1'b1; rsv_addr = 5'd7; rd(0, 5'd7, 1'b0);
      expect_out("rsv_ready_busy", S_RSVR, 64'd0);
      expect_out("busy_set", S_BUSY, 64'd1);
      sample();
      next_cycle();
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 64'hC0DE_0000_1111_2222;
      mdl[7] = wb_data;
      rd(0, 5'd7, 1'b0); rd(1, 5'd7, 1'b0);
      expect_out("wb_ready", S_WBR, 64'd1);
      expect_out("wb_bypass", S_RD1, mdl[7]);
      expect_out("busy_held", S_BUSY, 64'd3);
      sample();
      next_cycle();
      rd(0, 5'd7, 1'b0); rsv_addr = 5'd7;
      expect_out("busy_clr", S_BUSY, 64'd0);
      expect_out("rsv_ready_clr", S_RSVR, 64'd1);
      expect_out("wb_stored", S_RD0, mdl[7]);
      sample();
      next_cycle();
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      wa_en = 1'b1; wa_addr = 5'd7; wa_data = 64'h0123_4567_89AB_CDEF;
      mdl[7] = wa_data;
      rd(0, 5'd7, 1'b0);
      expect_out("wa_bypass7", S_RD0, mdl[7]);
      sample();
      next_cycle();
      rd(0, 5'd7, 1'b0); rsv_addr = 5'd7;
      expect_out("busy_new_prod", S_BUSY, 64'd1);
      expect_out("data_with_rsv", S_RD0, mdl[7]);
      expect_out("rsv_ready_new", S_RSVR, 64'd0);
      sample();

      // wa/wb collision on f3
      a_v = 64'hAAAA_0000_0000_0003;
      b_v = 64'hBBBB_0000_0000_0003;
      next_cycle();
      wa_en = 1'b1; wa_addr = 5'd3; wa_data = a_v;
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = b_v;
      rd(0, 5'd3, 1'b0);
      expect_out("wb_conflict", S_WBR, 64'd0);
      expect_out("bypass_wa", S_RD0, a_v);
      sample();
      next_cycle();
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = b_v;
      rd(0, 5'd3, 1'b0);
      expect_out("wb_retry", S_WBR, 64'd1);
      expect_out("bypass_wb", S_RD0, b_v);
      sample();
      next_cycle();
      rd(0, 5'd3, 1'b0);
      expect_out("wb_stored3", S_RD0, b_v);
      sample();

      // simultaneous wa and wb to different reserved registers
      c_v = 64'hCCCC_1010_0000_000A;
      d_v = 64'hDDDD_1111_0000_000B;
      next_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd10; sample();
      next_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd11; sample();
      next_cycle();
      wa_en = 1'b1; wa_addr = 5'd10; wa_data = c_v;
      wb_valid = 1'b1; wb_addr = 5'd11; wb_data = d_v;
      rd(0, 5'd10, 1'b0); rd(1, 5'd11, 1'b0);
      expect_out("dual_wb_ready", S_WBR, 64'd1);
      expect_out("dual_byp_wa", S_RD0, c_v);
      expect_out("dual_byp_wb", S_RD1, d_v);
      expect_out("dual_busy_pre", S_BUSY, 64'd3);
      sample();
      next_cycle();
      rd(0, 5'd10, 1'b0); rd(1, 5'd11, 1'b0);
      expect_out("dual_busy_clr", S_BUSY, 64'd0);
      expect_out("dual_reg_wa", S_RD0, c_v);
      expect_out("dual_reg_wb", S_RD1, d_v);
      sample();

      // dirty flag versus clean
      next_cycle();
      fs_clean = 1'b1; wa_en = 1'b1; wa_addr = 5'd12; wa_data = 64'h0000_0000_0000_0012;
      expect_out("dirty_before", S_DIRTY, 64'd1);
      sample();
      next_cycle();
      fs_clean = 1'b1;
      expect_out("dirty_write_wins", S_DIRTY, 64'd1);
      sample();
      next_cycle();
      expect_out("dirty_cleaned", S_DIRTY, 64'd0);
      sample();
      next_cycle();
      expect_out("dirty_hold", S_DIRTY, 64'd0);
      sample();

      // reset mid-operation with f9 busy and a wb pending
      g_v = 64'h9999_0000_ABCD_0009;
      next_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd9; sample();
      next_cycle();
      rd(0, 5'd9, 1'b0); rd(1, 5'd5, 1'b0); rsv_addr = 5'd9;
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = g_v;
      expect_out("busy9_pre", S_BUSY, 64'd1);
      expect_out("rsv_ready9_pre", S_RSVR, 64'd0);
      sample();
      #1; reset_n = 1'b0; #1;
      expect_out("busy_rst", S_BUSY, 64'd0);
      expect_out("byp_rst", S_RD0, 64'd0);
      expect_out("reg_rst", S_RD1, 64'd0);
      expect_out("rsv_ready_rst", S_RSVR, 64'd1);
      expect_out("dirty_rst", S_DIRTY, 64'd0);
      drain();
      wa_en = 1'b1; wa_addr = 5'd9; #1;
      expect_out("wb_ready_rst", S_WBR, 64'd0);
      drain();
      wa_en = 1'b0;
      for (int i = 0; i < NREG; i++) mdl[i] = 64'd0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      mdl[9] = g_v;
      expect_out("post_rst_wb_ready", S_WBR, 64'd1);
      expect_out("post_rst_bypass", S_RD0, g_v);
      sample();
      next_cycle();
      rd(0, 5'd9, 1'b0); rd(1, 5'd5, 1'b0);
      expect_out("post_rst_wb_stored", S_RD0, mdl[9]);
      expect_out("post_rst_f5", S_RD1, mdl[5]);
      expect_out("post_rst_busy", S_BUSY, 64'd0);
      expect_out("post_rst_dirty", S_DIRTY, 64'd1);
      sample();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fregs_sb.md
FREGS_SB -- requirements
Module: fregs_sb

Interface
REQ-001 Parameter FLEN, default 64: register width; legal values 32 or 64.
REQ-002 Parameter NRD, default 3: number of read ports (rs1/rs2/rs3 for fused multiply-add).
REQ-003 Parameter NREG, default 32: number of registers; address width AW = $clog2(NREG).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rd_addr  in  NRD*AW  read addresses, port k in slice k.
REQ-007 rd_single  in  NRD  per-port single-precision read (NaN-box check applies).
REQ-008 rd_data  out  NRD*FLEN  combinational read data.
REQ-009 rd_busy  out  NRD  scoreboard busy bit of each addressed register.
REQ-010 rsv_valid / rsv_addr / rsv_ready  in / in AW / out 1  destination reservation handshake.
REQ-011 wa_en / wa_addr / wa_data / wa_single  in 1 / AW / FLEN / 1  short-pipe write port, always accepted.
REQ-012 wb_valid / wb_addr / wb_data / wb_single / wb_ready  in 1 / AW / FLEN / 1 / out 1  long-latency (div/sqrt) write port with handshake.
REQ-013 fs_clean  in  1  pulse clearing the dirty flag.
REQ-014 fs_dirty  out  1  set once any register has been written.

Function
REQ-015 All NREG registers are writable; f0 is an ordinary register.
REQ-016 Write data: if *_single=1 and FLEN=64, store {32'hFFFFFFFF, data[31:0]}; otherwise store data unchanged.
REQ-017 Read: rd_data = register content, bypassed same cycle from an accepted write to the same address (wa over wb).
REQ-018 Read with rd_single=1 and FLEN=64: upper 32 bits not all ones -> return 64'hFFFFFFFF_7FC00000 (boxed canonical NaN).
REQ-019 FLEN=32: rd_single and *_single have no effect.
REQ-020 Write latency: register updated on the edge of acceptance; visible via bypass in the acceptance cycle.
REQ-021 rsv_ready = !busy[rsv_addr] (combinational); reservation fires when rsv_valid && rsv_ready and sets busy next edge.
REQ-022 rsv_valid with rsv_ready=0: no state change; requester holds its request.
REQ-023 Accepted write (wa_en, or wb_valid && wb_ready) clears busy of its address.
REQ-024 Reservation and write to the same address in one cycle: busy ends 1 (new producer wins); data is still written.
REQ-025 wb_ready = !(wa_en && wa_addr == wb_addr); wb holds data while wb_ready=0.
REQ-026 wa and wb to different addresses in one cycle: both written, both busy bits cleared.
REQ-027 Write to a non-busy register is legal: data written, busy stays 0.
REQ-028 rd_busy[k] reflects the registered busy bit, not same-cycle reservations or clears.
REQ-029 fs_dirty set on the edge after any accepted write; fs_clean clears it; a write in the same cycle wins (stays 1).

Reset
REQ-030 reset_n low asynchronously clears all registers to 0, all busy bits to 0, and fs_dirty to 0.
REQ-031 During reset, rd_data = 0 (or boxed NaN per REQ-018), rsv_ready = 1, and wb_ready follows REQ-025.
REQ-032 Reservations are lost on reset; post-reset writes are accepted normally.

Structure
REQ-033 Package fpu_pkg holds the FLEN default, the canonical NaN constants (32'h7FC00000, 64'hFFFFFFFF_7FC00000), the NaN-box upper constant, and the AW derivation.
REQ-034 One sub-module, fregs_unbox (the combinational per-port NaN-box check of REQ-018), is instantiated NRD times.

Verification
REQ-035 Reset, then read all addresses -> rd_data 0, rd_busy 0, fs_dirty 0, rsv_ready 1.
REQ-036 FLEN=64: wa write f5=32'h3F800000 with wa_single=1; read f5 with rd_single=1 -> 64'hFFFFFFFF_3F800000; write f6=64'h0000_0000_3F800000 with wa_single=0; read f6 with rd_single=1 -> 64'hFFFFFFFF_7FC00000.
REQ-037 Reserve f7 -> next cycle rsv_ready=0 for f7 and rd_busy=1; wb write f7 -> busy 0 next cycle; re-reserve in the same cycle as the write -> busy stays 1.
REQ-038 wa_en and wb_valid both to f3 -> wb_ready=0 and only wa data written; next cycle wb is accepted and f3 holds wb data; a read of f3 in each write cycle returns the bypassed value.
REQ-039 fs_clean in the same cycle as a write -> fs_dirty stays 1; fs_clean alone -> 0.
REQ-040 Assert reset_n mid-operation with f9 busy and a wb pending -> busy cleared and registers 0 immediately; after release, wb write accepted and data visible.
